// File: rtl/tcm_pkg.sv
// rtl/tcm_pkg.sv - shared TCM data-port widths, owner id and arbiter state types
package tcm_pkg;

  localparam int TCM_ADDR_W = 32;
  localparam int TCM_DATA_W = 32;
  localparam int TCM_TAG_W  = 11;
  localparam int TCM_STRB_W = 4;

  // Which requester issued an outstanding TCM transfer.
  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tcm_dport_arbiter_if.sv
// rtl/tcm_dport_arbiter_if.sv - bundled requester and TCM data-port signals of the arbiter
// Carries the m0 (CPU LSU) and m1 (loader/debug) request/response buses, the m1
// lock input and the mem_d_* side towards the TCM.
//   modport slave  : arbiter view (requests in, s_* out, TCM responses in)
//   modport master : environment view (drives requests and TCM responses)
interface tcm_dport_arbiter_if;
  import tcm_pkg::*;

  logic [TCM_ADDR_W-1:0] m0_addr_i,     m1_addr_i;
  logic [TCM_DATA_W-1:0] m0_data_wr_i,  m1_data_wr_i;
  logic                  m0_rd_i,       m1_rd_i;
  logic [TCM_STRB_W-1:0] m0_wr_i,       m1_wr_i;
  logic [TCM_TAG_W-1:0]  m0_tag_i,      m1_tag_i;
  logic                  m0_accept_o,   m1_accept_o;
  logic                  m0_ack_o,      m1_ack_o;
  logic [TCM_DATA_W-1:0] m0_data_rd_o,  m1_data_rd_o;
  logic [TCM_TAG_W-1:0]  m0_resp_tag_o, m1_resp_tag_o;
  logic                  m1_lock_i;

  logic [TCM_ADDR_W-1:0] s_addr_o;
  logic [TCM_DATA_W-1:0] s_data_wr_o;
  logic                  s_rd_o;
  logic [TCM_STRB_W-1:0] s_wr_o;
  logic [TCM_TAG_W-1:0]  s_tag_o;
  logic                  s_accept_i;
  logic                  s_ack_i;
  logic [TCM_DATA_W-1:0] s_data_rd_i;
  logic [TCM_TAG_W-1:0]  s_resp_tag_i;

  modport slave (
    input  m0_addr_i, m0_data_wr_i, m0_rd_i, m0_wr_i, m0_tag_i,
    input  m1_addr_i, m1_data_wr_i, m1_rd_i, m1_wr_i, m1_tag_i, m1_lock_i,
    output m0_accept_o, m0_ack_o, m0_data_rd_o, m0_resp_tag_o,
    output m1_accept_o, m1_ack_o, m1_data_rd_o, m1_resp_tag_o,
    output s_addr_o, s_data_wr_o, s_rd_o, s_wr_o, s_tag_o,
    input  s_accept_i, s_ack_i, s_data_rd_i, s_resp_tag_i
  );

  modport master (
    output m0_addr_i, m0_data_wr_i, m0_rd_i, m0_wr_i, m0_tag_i,
    output m1_addr_i, m1_data_wr_i, m1_rd_i, m1_wr_i, m1_tag_i, m1_lock_i,
    input  m0_accept_o, m0_ack_o, m0_data_rd_o, m0_resp_tag_o,
    input  m1_accept_o, m1_ack_o, m1_data_rd_o, m1_resp_tag_o,
    input  s_addr_o, s_data_wr_o, s_rd_o, s_wr_o, s_tag_o,
    output s_accept_i, s_ack_i, s_data_rd_i, s_resp_tag_i
  );

endinterface

// File: rtl/tcm_owner_fifo.sv
// rtl/tcm_owner_fifo.sv - 1-bit sync FIFO recording the owner of each outstanding TCM transfer
// Ports: clk_i, rst_ni (async active-low), push_i/data_i (owner id in),
//        pop_i (head consumed), full_o, empty_o, head_o (owner of oldest entry).
// Pop on empty is ignored; push on full is ignored unless a pop happens in the
// same cycle, in which case the head is read out before the new entry lands.
module tcm_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign head_o  = mem[rd_ptr];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tcm_dport_arbiter.sv
// rtl/tcm_dport_arbiter.sv - two-requester arbiter for the single TCM data port
// Ports: clk_i, rst_ni (async active-low), bus (tcm_dport_arbiter_if.slave):
//   m0 = CPU load/store unit, m1 = loader/debug master with lock, s_* = TCM mem_d_*.
// Requests pass to the TCM with zero latency; acks are routed back to the issuing
// master using an owner FIFO. m0 has default priority; m1 wins when m0 is idle,
// when it has stalled MAX_WAIT cycles, or while it holds the lock.
module tcm_dport_arbiter
  import tcm_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int MAX_WAIT    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tcm_dport_arbiter_if.slave   bus
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic          req0, req1;
  logic          fifo_full, fifo_empty, fifo_head;
  logic          pop, block, m1_pref, grant0, grant1;
  logic          accept0, accept1;

  assign req0 = bus.m0_rd_i | (|bus.m0_wr_i);
  assign req1 = bus.m1_rd_i | (|bus.m1_wr_i);

  // An ack on a full FIFO frees a slot in the same cycle, so it unblocks a grant.
  assign pop   = rst_ni & bus.s_ack_i & ~fifo_empty;
  assign block = ~rst_ni | (fifo_full & ~pop);

  // LOCKED forces the m1 path even with m1 idle, so m0 is starved by design.
  assign m1_pref = (state_q == ST_LOCKED)
                 | ((starve_cnt == SW'(MAX_WAIT)) & req1)
                 | (req1 & ~req0);
  assign grant1  = ~block & m1_pref;
  assign grant0  = ~block & ~m1_pref;

  assign accept0 = grant0 & req0 & bus.s_accept_i;
  assign accept1 = grant1 & req1 & bus.s_accept_i;

  assign bus.m0_accept_o = accept0;
  assign bus.m1_accept_o = accept1;

  assign bus.s_addr_o    = grant1 ? bus.m1_addr_i    : bus.m0_addr_i;
  assign bus.s_data_wr_o = grant1 ? bus.m1_data_wr_i : bus.m0_data_wr_i;
  assign bus.s_tag_o     = grant1 ? bus.m1_tag_i     : bus.m0_tag_i;
  assign bus.s_rd_o      = grant1 ? bus.m1_rd_i : (grant0 & bus.m0_rd_i);
  assign bus.s_wr_o      = grant1 ? bus.m1_wr_i : (grant0 ? bus.m0_wr_i : '0);

  assign bus.m0_ack_o      = pop & (owner_e'(fifo_head) == OWNER_M0);
  assign bus.m1_ack_o      = pop & (owner_e'(fifo_head) == OWNER_M1);
  assign bus.m0_data_rd_o  = bus.s_data_rd_i;
  assign bus.m1_data_rd_o  = bus.s_data_rd_i;
  assign bus.m0_resp_tag_o = bus.s_resp_tag_i;
  assign bus.m1_resp_tag_o = bus.s_resp_tag_i;

  tcm_owner_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept0 | accept1),
    .data_i  (accept1),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (!req1 || accept1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(MAX_WAIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_ARB;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:    if (accept1 && bus.m1_lock_i) state_d = ST_LOCKED;
      ST_LOCKED: if (!bus.m1_lock_i)           state_d = ST_ARB;
      default:   state_d = ST_ARB;
    endcase
  end

  ack_needs_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.s_ack_i && fifo_empty));

endmodule
